logic_op_checker: RTL and testbench
===================================

// Module: logic_op_checker
// PURPOSE
//  Synthesizable response checker for the bitwise-logic stimulus path. Accepts
//  (x, y, op, z) beats over a valid/ready handshake, recomputes the expected z,
//  compares it against the z under test, and counts checks and mismatches.
//  Captures the first failure and reports pass/fail after a programmed number
//  of beats. Sits downstream of any x/y/z stimulus driver as its consumer end.
// PARAMETERS
//  W      1   data width of x, y and z
//  CNT_W  8   width of the beat and error counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      async active-low reset
//  start          in   1      1-cycle pulse: arm a run of num_checks beats
//  num_checks     in   CNT_W  beats in the run; sampled on start
//  in_valid       in   1      beat present
//  in_ready       out  1      checker accepts a beat
//  in_x, in_y     in   W      operands
//  in_op          in   2      0=XOR 1=OR 2=AND 3=NOT(x)
//  in_z           in   W      value under test
//  busy           out  1      run in progress (CHECK or DRAIN)
//  done           out  1      1-cycle pulse at end of run
//  pass           out  1      err_count==0 at end of run; held until next start
//  chk_count      out  CNT_W  beats compared in this run
//  err_count      out  CNT_W  mismatching beats (saturates at all-ones)
//  first_err_idx  out  CNT_W  beat index (0-based) of the first mismatch
//  first_err_exp  out  W      expected z at the first mismatch
//  first_err_got  out  W      received z at the first mismatch
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0, including pass.
//  - FSM IDLE -> CHECK on start. CHECK -> DRAIN on the accept that makes
//    accepted==num_checks. DRAIN -> DONE after 1 cycle. DONE -> IDLE after 1
//    cycle. DONE asserts done for exactly that cycle.
//  - start with num_checks==0: IDLE -> DONE directly. done pulses; pass=1.
//  - start is ignored outside IDLE.
//  - start clears chk_count, err_count, first_err_*, and pass on the next edge.
//  - in_ready=1 only in CHECK. It is registered and drops on the edge of the
//    final accept, so there are never surplus accepts. Accept = in_valid&in_ready.
//  - Pipeline: an accepted beat is registered as stage-1 (exp, got, idx). On
//    the following edge, chk_count increments. If exp!=got, err_count
//    increments. Latency is 2 cycles from accept to the counter update.
//  - Expected z is computed bitwise over all W bits. NOT ignores y.
//  - first_err_* load only when err_count==0 at the first mismatch. They are
//    never overwritten within a run.
//  - err_count and chk_count saturate at 2^CNT_W-1 and never wrap.
//  - pass updates together with done. done and busy are mutually exclusive.
//  - in_valid may stay high without an accept. Data is held by the sender;
//    no protocol checks are performed on it.
//  - rst_n low mid-run: the run is aborted immediately. No done pulse occurs.
// STRUCTURE
//  - logic_op_pkg: localparams OP_XOR=0, OP_OR=1, OP_AND=2, OP_NOT=3, and the
//    state encodings S_IDLE, S_CHECK, S_DRAIN, S_DONE.
//  - Sub-module logic_op_eval: combinational (x, y, op) -> expected z,
//    parameter W. The checker instantiates it once. The driver side may reuse it.
// TESTING
//  1 W=1, N=3, beats (0,1,XOR,1)(0,0,OR,0)(0,0,NOT,1) -> done after the 3rd
//    beat + 2 cycles; chk=3, err=0, pass=1.
//  2 W=4, N=2, (4'hA,4'h5,AND,4'h1), then (4'hA,4'h5,OR,4'hF) -> err=1,
//    first_err_idx=0, exp=4'h0, got=4'h1, pass=0.
//  3 N=0 start -> done 1 cycle later, pass=1, in_ready never asserts.
//  4 in_valid toggled randomly, N=5 -> exactly 5 accepts; in_ready low after
//    the 5th accept.
//  5 CNT_W=2, N=3 all mismatching, then a 2nd run with 1 error ->
//    err saturates at 3; 2nd run reports err=1.
//  6 rst_n pulsed low mid-CHECK -> all outputs 0 asynchronously, no done,
//    next start runs cleanly.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared definitions for the bitwise-logic checker: operation codes and the
// checker's run-state encoding.
package logic_op_pkg;

  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/logic_op_eval.sv
// Combinational reference evaluator: (x, y, op) -> expected z, bitwise over W bits.
// Shared by the checker and, where needed, by stimulus drivers.
module logic_op_eval
  import logic_op_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   op,
  output logic [W-1:0] z
);

  // NOTE: z gets a default before the case so no path through the block
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    z = '0;
    case (op)
      OP_XOR:  z = x ^ y;
      OP_OR:   z = x | y;
      OP_AND:  z = x & y;
      OP_NOT:  z = ~x;
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_checker.sv
// Response checker for the bitwise-logic path: accepts (x, y, op, z) beats,
// recomputes z, and counts checks and mismatches over a programmed run.
module logic_op_checker
  import logic_op_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [1:0]       in_op,
  input  logic [W-1:0]     in_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [W-1:0]     first_err_exp,
  output logic [W-1:0]     first_err_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] acc_count;

  // Stage-1 holds one accepted beat: its expected and received z and index.
  logic             s1_valid;
  logic [W-1:0]     s1_exp;
  logic [W-1:0]     s1_got;
  logic [CNT_W-1:0] s1_idx;

  logic [W-1:0]     exp_z;
  logic             accept;
  logic             last_accept;
  logic             s1_mismatch;

  logic_op_eval #(.W(W)) u_eval (
    .x  (in_x),
    .y  (in_y),
    .op (in_op),
    .z  (exp_z)
  );

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && ((acc_count + CNT_ONE) == num_reg);
  assign s1_mismatch = s1_valid && (s1_exp != s1_got);

  // NOTE: all state here is sequential and uses non-blocking assignments, so
  // every right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      num_reg       <= '0;
      acc_count     <= '0;
      s1_valid      <= 1'b0;
      s1_exp        <= '0;
      s1_got        <= '0;
      s1_idx        <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      chk_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= accept;

      if (accept) begin
        s1_exp    <= exp_z;
        s1_got    <= in_z;
        s1_idx    <= acc_count;
        acc_count <= acc_count + CNT_ONE;
      end

      if (s1_valid) begin
        if (chk_count != CNT_MAX) chk_count <= chk_count + CNT_ONE;
        if (s1_mismatch) begin
          if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
          if (err_count == '0) begin
            first_err_idx <= s1_idx;
            first_err_exp <= s1_exp;
            first_err_got <= s1_got;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            num_reg       <= num_checks;
            acc_count     <= '0;
            chk_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            if (num_checks == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state    <= S_CHECK;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              pass     <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          // Ready drops on the final accept edge so no surplus beat is taken.
          if (last_accept) begin
            state    <= S_DRAIN;
            in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The last beat is retiring this edge; fold its result into pass.
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !s1_mismatch;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_checker.sv
// Self-checking bench for logic_op_checker: a W=4/CNT_W=8 instance and a
// W=1/CNT_W=2 instance share stimulus, selected by sel.
module tb_logic_op_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_checks = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_x = '0, in_y = '0, in_z = '0;
  logic [1:0] in_op = '0;

  logic       rdy_b, busy_b, done_b, pass_b;
  logic [7:0] chk_b, err_b, fidx_b;
  logic [3:0] fexp_b, fgot_b;
  logic       rdy_s, busy_s, done_s, pass_s;
  logic [1:0] chk_s, err_s, fidx_s;
  logic [0:0] fexp_s, fgot_s;

  logic       o_ready, o_busy, o_done, o_pass;
  logic [7:0] o_chk, o_err, o_fidx;
  logic [3:0] o_fexp, o_fgot;

  int checks = 0;
  int errors = 0;

  logic [3:0] bx [0:63];
  logic [3:0] by [0:63];
  logic [1:0] bop[0:63];
  logic [3:0] bz [0:63];

  always #5 clk = ~clk;

  logic_op_checker #(.W(4), .CNT_W(8)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .num_checks(num_checks),
    .in_valid(in_valid & sel), .in_ready(rdy_b),
    .in_x(in_x), .in_y(in_y), .in_op(in_op), .in_z(in_z),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .chk_count(chk_b), .err_count(err_b), .first_err_idx(fidx_b),
    .first_err_exp(fexp_b), .first_err_got(fgot_b)
  );

  logic_op_checker #(.W(1), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .num_checks(num_checks[1:0]),
    .in_valid(in_valid & ~sel), .in_ready(rdy_s),
    .in_x(in_x[0:0]), .in_y(in_y[0:0]), .in_op(in_op), .in_z(in_z[0:0]),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .chk_count(chk_s), .err_count(err_s), .first_err_idx(fidx_s),
    .first_err_exp(fexp_s), .first_err_got(fgot_s)
  );

  always_comb begin
    o_ready = sel ? rdy_b  : rdy_s;
    o_busy  = sel ? busy_b : busy_s;
    o_done  = sel ? done_b : done_s;
    o_pass  = sel ? pass_b : pass_s;
    o_chk   = sel ? chk_b  : {6'd0, chk_s};
    o_err   = sel ? err_b  : {6'd0, err_s};
    o_fidx  = sel ? fidx_b : {6'd0, fidx_s};
    o_fexp  = sel ? fexp_b : {3'd0, fexp_s};
    o_fgot  = sel ? fgot_b : {3'd0, fgot_s};
  end

  // Reference: the spec's operation table applied to the active width.
  function automatic logic [3:0] ref_z(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] op, input logic [3:0] mask);
    case (op)
      2'd0:    return (x ^ y) & mask;
      2'd1:    return (x | y) & mask;
      2'd2:    return (x & y) & mask;
      default: return (~x) & mask;
    endcase
  endfunction

  task automatic set_beat(input int i, input logic [3:0] x, input logic [3:0] y,
                          input logic [1:0] op, input logic [3:0] z);
    bx[i] = x; by[i] = y; bop[i] = op; bz[i] = z;
  endtask

  task automatic fill_random(input int n, input int bad_pct);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      bx[i] = 4'($urandom); by[i] = 4'($urandom); bop[i] = 2'($urandom);
      e = ref_z(bx[i], by[i], bop[i], 4'hF);
      bz[i] = ($urandom_range(99) < bad_pct) ? (e ^ 4'($urandom_range(15, 1))) : e;
    end
  endtask

  // Runs one programmed run on the selected instance and checks it end to end.
  task automatic run_checked(input string name, input int n, input int vpct);
    logic [3:0] mask, e, exp_e, exp_g;
    logic [7:0] exp_idx, exp_err, exp_chk;
    int cap, nerr, acc, cyc;
    logic rdy, vld;
    mask = sel ? 4'hF : 4'h1;
    cap  = sel ? 255 : 3;
    nerr = 0; exp_idx = '0; exp_e = '0; exp_g = '0;
    for (int i = 0; i < n; i++) begin
      e = ref_z(bx[i], by[i], bop[i], mask);
      if (e != (bz[i] & mask)) begin
        if (nerr == 0) begin exp_idx = 8'(i); exp_e = e; exp_g = bz[i] & mask; end
        if (nerr < cap) nerr++;
      end
    end
    exp_err = 8'(nerr);
    exp_chk = 8'((n < cap) ? n : cap);

    @(negedge clk); start = 1'b1; num_checks = 8'(n);
    @(negedge clk); start = 1'b0;

    if (n == 0) begin
      checks++;
      if ({o_done, o_pass, o_ready, o_busy} !== 4'b1100) begin
        errors++; $display("FAIL %s zero_done: got done/pass/ready/busy=%b want 1100", name,
                           {o_done, o_pass, o_ready, o_busy});
      end
      @(negedge clk);
      checks++;
      if ({o_done, o_pass, o_ready, o_busy} !== 4'b0100) begin
        errors++; $display("FAIL %s zero_after: got done/pass/ready/busy=%b want 0100", name,
                           {o_done, o_pass, o_ready, o_busy});
      end
      return;
    end

    checks++;
    if ({o_ready, o_busy, o_done, o_pass, o_chk, o_err} !== {4'b1100, 16'h0000}) begin
      errors++; $display("FAIL %s armed: got rdy/busy/done/pass=%b chk=%0d err=%0d want 1100 0 0",
                         name, {o_ready, o_busy, o_done, o_pass}, o_chk, o_err);
    end

    acc = 0; cyc = 0;
    while (acc < n && cyc < 50 * n + 50) begin
      vld = ($urandom_range(99) < vpct);
      in_valid = vld;
      in_x = bx[acc]; in_y = by[acc]; in_op = bop[acc]; in_z = bz[acc];
      rdy = o_ready;
      @(posedge clk);
      if (vld && rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (acc != n) begin
      errors++; $display("FAIL %s accept_timeout: got %0d accepts want %0d", name, acc, n);
      in_valid = 1'b0;
      return;
    end

    // Keep offering a beat through DRAIN/DONE: none may be taken.
    in_valid = 1'b1;
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b010) begin
      errors++; $display("FAIL %s drain: got rdy/busy/done=%b want 010", name, {o_ready, o_busy, o_done});
    end
    @(negedge clk);
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b001) begin
      errors++; $display("FAIL %s done_pulse: got rdy/busy/done=%b want 001", name, {o_ready, o_busy, o_done});
    end
    checks++;
    if (o_chk !== exp_chk || o_err !== exp_err) begin
      errors++; $display("FAIL %s counts: got chk=%0d err=%0d want chk=%0d err=%0d",
                         name, o_chk, o_err, exp_chk, exp_err);
    end
    checks++;
    if (o_fidx !== exp_idx || o_fexp !== exp_e || o_fgot !== exp_g) begin
      errors++; $display("FAIL %s first_err: got idx=%0d exp=%h got=%h want idx=%0d exp=%h got=%h",
                         name, o_fidx, o_fexp, o_fgot, exp_idx, exp_e, exp_g);
    end
    checks++;
    if (o_pass !== (nerr == 0)) begin
      errors++; $display("FAIL %s pass: got %b want %b", name, o_pass, (nerr == 0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_done, o_pass} !== {3'b000, (nerr == 0)} || o_chk !== exp_chk) begin
      errors++; $display("FAIL %s after_done: got rdy/busy/done/pass=%b chk=%0d want %b chk=%0d", name,
                         {o_ready, o_busy, o_done, o_pass}, o_chk, {3'b000, (nerr == 0)}, exp_chk);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_ready, o_busy, o_done, o_pass, o_chk, o_err, o_fidx, o_fexp, o_fgot} !== '0) begin
        errors++; $display("FAIL reset_state sel=%0d: got rdy/busy/done/pass=%b chk=%0d err=%0d idx=%0d",
                           s, {o_ready, o_busy, o_done, o_pass}, o_chk, o_err, o_fidx);
      end
    end
    sel = 1'b1;
  endtask

  task automatic test_basic_w1();
    sel = 1'b0;
    set_beat(0, 4'h0, 4'h1, 2'd0, 4'h1);
    set_beat(1, 4'h0, 4'h0, 2'd1, 4'h0);
    set_beat(2, 4'h0, 4'h0, 2'd3, 4'h1);
    run_checked("basic_w1", 3, 100);
  endtask

  task automatic test_first_err();
    sel = 1'b1;
    set_beat(0, 4'hA, 4'h5, 2'd2, 4'h1);
    set_beat(1, 4'hA, 4'h5, 2'd1, 4'hF);
    run_checked("first_err", 2, 100);
  endtask

  task automatic test_zero();
    sel = 1'b1;
    run_checked("zero_run", 0, 100);
  endtask

  task automatic test_random_valid();
    sel = 1'b1;
    fill_random(5, 40);
    run_checked("rand_valid_n5", 5, 50);
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(20, 1);
      fill_random(n, 25);
      run_checked("rand_run", n, $urandom_range(90, 30));
    end
  endtask

  task automatic test_saturate();
    sel = 1'b0;
    set_beat(0, 4'h1, 4'h0, 2'd0, 4'h0);
    set_beat(1, 4'h1, 4'h1, 2'd2, 4'h0);
    set_beat(2, 4'h0, 4'h0, 2'd3, 4'h0);
    run_checked("sat_all_bad", 3, 70);
    set_beat(0, 4'h0, 4'h0, 2'd1, 4'h0);
    set_beat(1, 4'h1, 4'h0, 2'd1, 4'h0);
    set_beat(2, 4'h1, 4'h1, 2'd0, 4'h0);
    run_checked("sat_second", 3, 70);
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    fill_random(10, 50);
    @(negedge clk); start = 1'b1; num_checks = 8'd10;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_x = bx[i]; in_y = by[i]; in_op = bop[i]; in_z = bz[i];
      @(negedge clk);
    end
    checks++;
    if (o_busy !== 1'b1 || o_chk === 8'd0) begin
      errors++; $display("FAIL mid_run_pre: got busy=%b chk=%0d want busy=1 chk>0", o_busy, o_chk);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_busy, o_done, o_pass, o_chk, o_err, o_fidx, o_fexp, o_fgot} !== '0) begin
      errors++; $display("FAIL mid_run_reset: got rdy/busy/done/pass=%b chk=%0d err=%0d",
                         {o_ready, o_busy, o_done, o_pass}, o_chk, o_err);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0) begin
        errors++; $display("FAIL mid_run_no_done: got done=%b want 0", o_done);
      end
    end
    rst_n = 1'b1;
    fill_random(4, 0);
    run_checked("post_reset_run", 4, 80);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic_w1();
    test_first_err();
    test_zero();
    test_random_valid();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
